// File: rtl/sram_like_slave.sv
// sram_like_slave
//   Bridges an SRAM-like initiator (req/addr_ok, data_ok) onto a synchronous
//   single-port SRAM with a one-cycle read latency. It allows up to MAX_OUTST
//   accepted-but-unanswered requests and returns responses strictly in order.
//
// Build option:
//   SRAM_LIKE_DELAY_EN - adds a 16-bit LFSR. The LFSR randomly withholds
//                        addr_ok and holds back each response for 0..3
//                        extra cycles. All responses then pass through the
//                        FIFO, with no bypass.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   req, wr, size     request valid, write flag, transfer size (size unused)
//   addr, wstrb,      byte address, byte write enables, write data
//   wdata
//   addr_ok           request accepted this cycle when req = 1
//   data_ok, rdata    response valid (no back-pressure), read data (0 on writes)
//   ram_en, ram_wen,  SRAM enable, byte write enables, word address,
//   ram_addr,         write data
//   ram_wdata
//   ram_rdata         SRAM read data, valid one cycle after ram_en
//
// Handshake: a request transfers in the cycle where req && addr_ok. The
// initiator may change or drop req at any time before that. A response is a
// one-cycle data_ok pulse that the initiator must take as soon as it appears.
module sram_like_slave #(
  parameter int ADDR_W    = 16,
  parameter int MAX_OUTST = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              wr,
  input  logic [1:0]        size,
  input  logic [31:0]       addr,
  input  logic [3:0]        wstrb,
  input  logic [31:0]       wdata,
  output logic              addr_ok,
  output logic              data_ok,
  output logic [31:0]       rdata,
  output logic              ram_en,
  output logic [3:0]        ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam int CNT_W = $clog2(MAX_OUTST + 1);
  localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTST);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTST - 1);

  // out_cnt counts the capture stage plus the FIFO entries. fifo_cnt counts
  // only the FIFO entries. Full and empty come from these counts.
  logic [CNT_W-1:0] out_cnt;
  logic [CNT_W-1:0] fifo_cnt;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [31:0]      fifo_mem [MAX_OUTST];
  logic             cap_valid;  // an SRAM access issued last cycle
  logic             cap_wr;
  logic [31:0]      cap_data;
  logic             accept;
  logic             push;
  logic             pop;
  logic             gate_ok;

  // Only the word-address bits of addr are used. size is not interpreted.
  logic unused_bits;
  assign unused_bits = ^{size, addr[31:ADDR_W+2], addr[1:0]};

  assign cap_data = cap_wr ? 32'h0 : ram_rdata;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

`ifdef SRAM_LIKE_DELAY_EN
  logic [15:0] lfsr;
  logic [1:0]  head_wait;
  logic        new_head;

  assign gate_ok = (lfsr[1:0] != 2'b00);
  // An entry becomes the head when it is pushed into an empty FIFO, or when
  // the FIFO is being drained to empty at the same time. It also becomes the
  // head when the entry in front of it pops.
  assign new_head = (push && ((fifo_cnt == '0) || (pop && fifo_cnt == CNT_W'(1))))
                  || (pop && fifo_cnt > CNT_W'(1));
`else
  assign gate_ok = 1'b1;
`endif

  always_comb begin
    addr_ok   = 1'b0;
    accept    = 1'b0;
    data_ok   = 1'b0;
    rdata     = 32'h0;
    ram_en    = 1'b0;
    ram_wen   = 4'h0;
    ram_addr  = '0;
    ram_wdata = 32'h0;
    push      = 1'b0;
    pop       = 1'b0;
    if (!reset) begin
      addr_ok = (out_cnt < MAX_CNT) && (fifo_cnt < MAX_CNT) && gate_ok;
      accept  = req && addr_ok;
      if (accept) begin
        ram_en    = 1'b1;
        ram_wen   = wr ? wstrb : 4'h0;
        ram_addr  = addr[ADDR_W+1:2];
        ram_wdata = wdata;
      end
`ifdef SRAM_LIKE_DELAY_EN
      push = cap_valid;
      pop  = (fifo_cnt != '0) && (head_wait == 2'd0);
      if (pop) begin
        data_ok = 1'b1;
        rdata   = fifo_mem[rd_ptr];
      end
`else
      if (fifo_cnt == '0) begin
        // The FIFO is empty, so the SRAM output goes straight to the response.
        if (cap_valid) begin
          data_ok = 1'b1;
          rdata   = cap_data;
        end
      end else begin
        push    = cap_valid;
        pop     = 1'b1;
        data_ok = 1'b1;
        rdata   = fifo_mem[rd_ptr];
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_cnt   <= '0;
      fifo_cnt  <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      cap_valid <= 1'b0;
      cap_wr    <= 1'b0;
    end else begin
      cap_valid <= accept;
      cap_wr    <= wr;
      if (accept && !data_ok) begin
        out_cnt <= out_cnt + CNT_W'(1);
      end else if (!accept && data_ok) begin
        out_cnt <= out_cnt - CNT_W'(1);
      end
      if (push && !pop) begin
        fifo_cnt <= fifo_cnt + CNT_W'(1);
      end else if (!push && pop) begin
        fifo_cnt <= fifo_cnt - CNT_W'(1);
      end
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= cap_data;
    end
  end

`ifdef SRAM_LIKE_DELAY_EN
  // LFSR with taps 16,14,13,11. head_wait is loaded with a fresh 0..3 each
  // time a new entry reaches the head of the FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr      <= 16'hACE1;
      head_wait <= 2'd0;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      if (new_head) begin
        head_wait <= lfsr[3:2];
      end else if (head_wait != 2'd0) begin
        head_wait <= head_wait - 2'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sram_like_slave.sv
`timescale 1ns/1ps
module tb_sram_like_slave;
  localparam int ADDR_W    = 16;
  localparam int MAX_OUTST = 2;

  // clock / reset
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic              req = 1'b0;
  logic              wr = 1'b0;
  logic [1:0]        size = 2'd0;
  logic [31:0]       addr = 32'h0;
  logic [3:0]        wstrb = 4'h0;
  logic [31:0]       wdata = 32'h0;
  logic              addr_ok;
  logic              data_ok;
  logic [31:0]       rdata;
  logic              ram_en;
  logic [3:0]        ram_wen;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata = 32'h0;

  sram_like_slave #(.ADDR_W(ADDR_W), .MAX_OUTST(MAX_OUTST)) dut (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size), .addr(addr),
    .wstrb(wstrb), .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok),
    .rdata(rdata), .ram_en(ram_en), .ram_wen(ram_wen), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // bookkeeping
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_acc = 0;
  int n_resp = 0;
  int max_seen = 0;
  int acc_cyc = 0;
  logic [3:0]  seen_wen = 4'h0;
  logic [15:0] seen_addr = 16'h0;
  bit prev_acc = 1'b0;

  logic [31:0] ref_mem [0:255];
  logic [31:0] exp_q[$];
  logic [31:0] resp_log[$];
  int          resp_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] preset_word(input int i);
    return (i == 8) ? 32'hFFFF_FFFF : 32'h1000_0000 + i;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] log_at(input int i);
    return (i < resp_log.size()) ? resp_log[i] : 32'hDEAD_BEEF;
  endfunction

  // SRAM device on the ram_* port: one-cycle read, byte-masked write
  initial begin : sram_dev
    logic [31:0] sram [0:255];
    logic [31:0] tmp;
    for (int i = 0; i < 256; i++) sram[i] = preset_word(i);
    forever begin
      @(posedge clk);
      if (ram_en) begin
        tmp = sram[ram_addr[7:0]];
        ram_rdata <= tmp;
        for (int b = 0; b < 4; b++)
          if (ram_wen[b]) tmp[8*b +: 8] = ram_wdata[8*b +: 8];
        sram[ram_addr[7:0]] = tmp;
      end
    end
  end

  // scoreboard / compare process, sampling at the falling edge
  initial begin : compare
    int q0;
    int widx;
    logic [31:0] e;
    for (int i = 0; i < 256; i++) ref_mem[i] = preset_word(i);
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("rst_addr_ok", addr_ok, 0);
        chk("rst_data_ok", data_ok, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_ram_en", ram_en, 0);
        chk("rst_ram_wen", ram_wen, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_wdata", ram_wdata, 0);
        exp_q.delete();
        prev_acc = 1'b0;
      end else begin
        q0 = exp_q.size();
        if (data_ok) begin
          n_resp++;
          resp_log.push_back(rdata);
          resp_cyc.push_back(cyc);
          chk("resp_pending", q0 != 0, 1);
          if (q0 != 0) begin
            e = exp_q.pop_front();
            chk("rdata", rdata, e);
          end
        end
`ifndef SRAM_LIKE_DELAY_EN
        chk("data_ok_latency", data_ok, prev_acc);
        chk("addr_ok", addr_ok, q0 < MAX_OUTST);
`else
        if (addr_ok) chk("addr_ok_when_full", q0 >= MAX_OUTST, 0);
`endif
        if (req && addr_ok) begin
          chk("ram_en", ram_en, 1);
          chk("ram_wen", ram_wen, wr ? wstrb : 4'h0);
          chk("ram_addr", ram_addr, addr[ADDR_W+1:2]);
          chk("ram_wdata", ram_wdata, wdata);
          widx = int'(addr[9:2]);
          if (wr) begin
            for (int b = 0; b < 4; b++)
              if (wstrb[b]) ref_mem[widx][8*b +: 8] = wdata[8*b +: 8];
            exp_q.push_back(32'h0);
          end else begin
            exp_q.push_back(ref_mem[widx]);
          end
          n_acc++;
          prev_acc = 1'b1;
        end else begin
          chk("ram_en_idle", ram_en, 0);
          chk("ram_wen_idle", ram_wen, 0);
          prev_acc = 1'b0;
        end
        if (exp_q.size() > max_seen) max_seen = exp_q.size();
      end
    end
  end

  // driver tasks
  task automatic do_req(input logic w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d);
    int waited = 0;
    req = 1'b1; wr = w; addr = a; wstrb = s; wdata = d; size = 2'd2;
    @(negedge clk);
    while (!addr_ok && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    chk("accept_bound", addr_ok, 1);
    acc_cyc   = cyc;
    seen_wen  = ram_wen;
    seen_addr = ram_addr;
    @(posedge clk); #1;
    req = 1'b0; wr = 1'b0; wstrb = 4'h0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic clear_log();
    resp_log.delete();
    resp_cyc.delete();
  endtask

  initial begin : main
    logic [31:0] stream_exp [0:7];
    int got;
    int guard;
    int cnt;
    int n_hold;
    int acc_start;
    int resp_start;
    stream_exp[0] = 32'h1000_0000; stream_exp[1] = 32'h1000_0001;
    stream_exp[2] = 32'h1000_0002; stream_exp[3] = 32'h1000_0003;
    stream_exp[4] = 32'h1234_5678; stream_exp[5] = 32'h1000_0005;
    stream_exp[6] = 32'h1000_0006; stream_exp[7] = 32'h1000_0007;

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("addr_ok_after_reset", addr_ok, 1);
    @(posedge clk); #1;

    // write 0x10 followed by a read of 0x10
    clear_log();
    do_req(1'b1, 32'h0000_0010, 4'hF, 32'h1234_5678);
    chk("wr_ram_wen", seen_wen, 4'hF);
    chk("wr_ram_addr", seen_addr, 16'd4);
    drain();
    chk("wr_resp_count", resp_log.size(), 1);
    chk("wr_resp_rdata", log_at(0), 32'h0);
`ifndef SRAM_LIKE_DELAY_EN
    if (resp_cyc.size() > 0) chk("wr_latency", resp_cyc[0] - acc_cyc, 1);
`endif
    clear_log();
    do_req(1'b0, 32'h0000_0010, 4'h0, 32'h0);
    drain();
    chk("rd_resp_rdata", log_at(0), 32'h1234_5678);

    // byte write into the preset word at 0x20
    clear_log();
    do_req(1'b1, 32'h0000_0020, 4'b0010, 32'h0000_AB00);
    do_req(1'b0, 32'h0000_0020, 4'h0, 32'h0);
    drain();
    chk("bw_wr_rdata", log_at(0), 32'h0);
    chk("bw_rd_rdata", log_at(1), 32'hFFFF_ABFF);

    // streaming reads of words 0..7
    clear_log();
`ifndef SRAM_LIKE_DELAY_EN
    req = 1'b1; wr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      addr = 32'(i * 4);
      @(negedge clk);
      chk("stream_accept", addr_ok, 1);
      @(posedge clk); #1;
    end
    req = 1'b0;
`else
    for (int i = 0; i < 8; i++) do_req(1'b0, 32'(i * 4), 4'h0, 32'h0);
`endif
    drain();
    chk("stream_count", resp_log.size(), 8);
    for (int i = 0; i < 8; i++) chk("stream_data", log_at(i), stream_exp[i]);
`ifndef SRAM_LIKE_DELAY_EN
    for (int i = 1; i < resp_cyc.size(); i++)
      chk("stream_back_to_back", resp_cyc[i] - resp_cyc[0], i);
`endif

    // reset while reads are pending
`ifdef SRAM_LIKE_DELAY_EN
    n_hold = 2;
`else
    n_hold = 1;
`endif
    got = 0; guard = 0;
    req = 1'b1; wr = 1'b0; addr = 32'h0000_0040;
    while (got < n_hold && guard < 200) begin
      @(negedge clk);
      if (addr_ok) got++;
      @(posedge clk); #1;
      addr = addr + 32'd4;
      guard++;
    end
    chk("midreset_accepts", got, n_hold);
    req = 1'b0;
    reset = 1'b1;
    clear_log();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("addr_ok_after_midreset", addr_ok, 1);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (data_ok) cnt++;
      @(negedge clk);
    end
    chk("no_data_ok_after_reset", cnt, 0);
    @(posedge clk); #1;

    // 1000 random requests
    acc_start  = n_acc;
    resp_start = n_resp;
    guard = 0;
    while (n_acc - acc_start < 1000 && guard < 20000) begin
      req   = ($urandom_range(0, 3) != 0);
      wr    = 1'($urandom_range(0, 1));
      size  = 2'($urandom_range(0, 2));
      addr  = ($urandom & 32'hFFFC_0003) | (32'($urandom_range(0, 255)) << 2);
      wstrb = 4'($urandom_range(0, 15));
      wdata = $urandom;
      @(posedge clk); #1;
      guard++;
    end
    req = 1'b0;
    drain();
    chk("rand_accepted", n_acc - acc_start, 1000);
    chk("rand_responses", n_resp - resp_start, 1000);
    chk("max_outstanding", max_seen <= MAX_OUTST, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sram_like_slave.md
SRAM_LIKE_SLAVE -- requirements
Module: sram_like_slave

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, meaning the SRAM word-address width; the SRAM address is addr[ADDR_W+1:2].
REQ-002 The block SHALL have parameter MAX_OUTST, default 2, meaning the maximum number of accepted-but-unanswered requests (legal range 1..4).
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 req  input  1  initiator request valid.
REQ-006 wr  input  1  1 = write, 0 = read.
REQ-007 size  input  2  transfer size (0 = byte, 1 = half, 2 = word); accepted and not otherwise interpreted.
REQ-008 addr  input  32  byte address.
REQ-009 wstrb  input  4  byte-write enables, used only when wr = 1.
REQ-010 wdata  input  32  write data.
REQ-011 addr_ok  output  1  request accepted this cycle when req = 1.
REQ-012 data_ok  output  1  response valid; this output has no back-pressure.
REQ-013 rdata  output  32  read data; 0 for write responses.
REQ-014 ram_en  output  1  synchronous SRAM enable.
REQ-015 ram_wen  output  4  SRAM byte write enables.
REQ-016 ram_addr  output  ADDR_W  SRAM word address.
REQ-017 ram_wdata  output  32  SRAM write data.
REQ-018 ram_rdata  input  32  SRAM read data, valid one cycle after ram_en.

Function
REQ-019 Handshake:
- A request SHALL be accepted in cycle T iff req && addr_ok in T.
- addr_ok SHALL be 1 only when the outstanding count < MAX_OUTST and the response buffer has a free slot.
REQ-020 SRAM issue:
- On acceptance in T, the block SHALL drive, in the same cycle T: ram_en = 1, ram_addr = addr[ADDR_W+1:2], ram_wdata = wdata.
- ram_wen SHALL be wstrb when wr = 1, else 4'h0.
- With no acceptance, ram_en = 0 and ram_wen = 0.
REQ-021 Capture: in T+1 the block SHALL capture the response {wr, wr ? 0 : ram_rdata} into a MAX_OUTST-entry in-order response FIFO.
- When the FIFO is empty and no delay applies, the response SHALL bypass the FIFO so that data_ok = 1 in T+1 (1-cycle latency).
REQ-022 Ordering: responses SHALL be returned strictly in acceptance order, with exactly one data_ok pulse per accepted request, writes included.
REQ-023 Outstanding count:
- It SHALL increment on acceptance and decrement on data_ok.
- When both occur in the same cycle, the count SHALL remain unchanged.
- It SHALL never exceed MAX_OUTST or go below 0.
REQ-024 Back-to-back: with continuous req and no delay, the block SHALL sustain one acceptance and one data_ok per cycle (throughput 1).
REQ-025 FIFO pointers SHALL wrap modulo MAX_OUTST; full and empty SHALL be distinguished by the count, not by pointer equality.
REQ-026 Hold rule: req, wr, size, addr, wstrb and wdata SHALL be sampled only in the acceptance cycle; a req withdrawn before addr_ok is not an error and SHALL produce no response.

Reset
REQ-027 While reset = 1, the block SHALL hold addr_ok = 0, data_ok = 0, rdata = 0, ram_en = 0, ram_wen = 0, ram_addr = 0, ram_wdata = 0.
REQ-028 Reset SHALL clear the count, the FIFO pointers and the delay state.
REQ-029 Reset asserted mid-transaction SHALL discard all pending responses; no data_ok SHALL appear for requests accepted before reset.
REQ-030 addr_ok SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-031 Macro SRAM_LIKE_DELAY_EN SHALL be the single build option.
REQ-032 When SRAM_LIKE_DELAY_EN is defined:
- A 16-bit LFSR (seed 16'hACE1 on reset, polynomial x^16+x^14+x^13+x^11+1, advancing every cycle) SHALL gate addr_ok.
- addr_ok SHALL be suppressed in any cycle where lfsr[1:0] == 2'b00.
- Each FIFO head SHALL be presented on data_ok only after lfsr[3:2] additional cycles, sampled when the head entry becomes the head (0..3 cycles).
- The bypass path is disabled in this mode.
REQ-033 When SRAM_LIKE_DELAY_EN is undefined: no LFSR SHALL exist, addr_ok SHALL depend only on REQ-019, and latency SHALL be exactly 1 cycle.

Verification
REQ-034 Write then read, macro off:
- Write addr=0x0000_0010, wdata=0x1234_5678, wstrb=4'hF in T -> ram_wen=4'hF and ram_addr=4 in T; data_ok=1 with rdata=0 in T+1.
- Read 0x10 -> rdata=0x1234_5678 one cycle after acceptance.
REQ-035 Byte write:
- Word 0x20 preset to 0xFFFF_FFFF; write wstrb=4'b0010, wdata=0x0000_AB00 -> subsequent read returns 0xFFFF_ABFF.
REQ-036 Streaming:
- 8 consecutive reads of 0x0,0x4,...,0x1C with req held high -> 8 acceptances in 8 cycles; data_ok high for 8 consecutive cycles; data in address order.
REQ-037 Macro on, random delay:
- 1000 random requests -> count never exceeds MAX_OUTST=2; responses match a reference memory in order; data_ok pulses total exactly 1000.
REQ-038 Reset mid-operation, macro on:
- Accept 2 reads, assert reset for 1 cycle before either data_ok -> no data_ok in the following 10 cycles.
- addr_ok=1 in the first cycle after reset deasserts.
